phase_delta_slewer: RTL



---
 rtl/phase_pkg.sv | 10 +
 rtl/phase_slew_step.sv | 32 +++
 rtl/phase_delta_slewer.sv | 113 +++++++++++
 3 files changed

// File: rtl/phase_pkg.sv
// Shared widths and FSM state encoding for the phase-delta slewer.
package phase_pkg;
  localparam int PHASE_W = 32;
  localparam int SHIFT_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_t;
endpackage

// File: rtl/phase_slew_step.sv
// Combinational exponential slew step: moves i_current toward i_target by
// (|diff| >> shift), never less than 1, landing exactly on the target.
module phase_slew_step #(
  parameter int PHASE_W = phase_pkg::PHASE_W,
  parameter int SHIFT_W = phase_pkg::SHIFT_W
) (
  input  logic [PHASE_W-1:0] i_current,
  input  logic [PHASE_W-1:0] i_target,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [PHASE_W-1:0] o_next,
  output logic               o_done
);
  logic [PHASE_W:0]   w_sub;
  logic               w_desc;
  logic [PHASE_W-1:0] w_mag;
  logic [PHASE_W-1:0] w_shifted;
  logic [PHASE_W-1:0] w_step;
  logic [PHASE_W-1:0] w_one;

  assign w_one = {{(PHASE_W-1){1'b0}}, 1'b1};

  // Extra MSB is the borrow: set means target is below current (descend).
  assign w_sub     = {1'b0, i_target} - {1'b0, i_current};
  assign w_desc    = w_sub[PHASE_W];
  assign w_mag     = w_desc ? (i_current - i_target) : w_sub[PHASE_W-1:0];
  assign w_shifted = w_mag >> i_shift;
  assign w_step    = ((32'(i_shift) >= 32'(PHASE_W)) || (w_shifted == '0)) ? w_one : w_shifted;

  assign o_done = (w_mag <= w_step);
  assign o_next = o_done ? i_target :
                  (w_desc ? (i_current - w_step) : (i_current + w_step));
endmodule

// File: rtl/phase_delta_slewer.sv
// Phase-delta producer: jumps or glides toward an accepted target on frame ticks.
// Optional PHASE_SLEW_RETARGET_EN lets a new target be accepted during a glide.
module phase_delta_slewer #(
  parameter int PHASE_W = phase_pkg::PHASE_W,
  parameter int SHIFT_W = phase_pkg::SHIFT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PHASE_W-1:0] i_target,
  input  logic               i_target_valid,
  output logic               o_target_ready,
  input  logic [SHIFT_W-1:0] i_slew_shift,
  input  logic               i_tick,
  output logic [PHASE_W-1:0] o_phase_delta,
  output logic               o_phase_delta_valid,
  output logic               o_busy
);
  import phase_pkg::*;

  state_t             r_state;
  logic [PHASE_W-1:0] r_delta;
  logic               r_valid;
  logic [PHASE_W-1:0] r_target;
  logic [SHIFT_W-1:0] r_shift;

  state_t             w_state_nxt;
  logic [PHASE_W-1:0] w_delta_nxt;
  logic               w_valid_nxt;
  logic [PHASE_W-1:0] w_target_nxt;
  logic [SHIFT_W-1:0] w_shift_nxt;
  logic [PHASE_W-1:0] w_step_next;
  logic               w_step_done;
  logic               w_accept;

  phase_slew_step #(.PHASE_W(PHASE_W), .SHIFT_W(SHIFT_W)) u_step (
    .i_current (r_delta),
    .i_target  (r_target),
    .i_shift   (r_shift),
    .o_next    (w_step_next),
    .o_done    (w_step_done)
  );

`ifdef PHASE_SLEW_RETARGET_EN
  assign o_target_ready = !i_rst;
`else
  assign o_target_ready = (r_state == IDLE) && !i_rst;
`endif

  assign w_accept            = i_target_valid && o_target_ready;
  assign o_phase_delta       = r_delta;
  assign o_phase_delta_valid = r_valid;
  assign o_busy              = (r_state == SLEW);

  always_comb begin
    w_state_nxt  = r_state;
    w_delta_nxt  = r_delta;
    w_valid_nxt  = 1'b0;
    w_target_nxt = r_target;
    w_shift_nxt  = r_shift;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (i_slew_shift == '0) begin
            w_delta_nxt = i_target;
            w_valid_nxt = 1'b1;
          end else begin
            w_target_nxt = i_target;
            w_shift_nxt  = i_slew_shift;
            w_state_nxt  = SLEW;
          end
        end
      end
      SLEW: begin
        if (i_tick) begin
          w_delta_nxt = w_step_next;
          w_valid_nxt = 1'b1;
          if (w_step_done) w_state_nxt = IDLE;
        end
`ifdef PHASE_SLEW_RETARGET_EN
        // New target takes effect from the next tick; a zero shift jumps now.
        if (w_accept) begin
          w_target_nxt = i_target;
          w_shift_nxt  = i_slew_shift;
          if (i_slew_shift == '0) begin
            w_delta_nxt = i_target;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SLEW;
          end
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_delta  <= '0;
      r_valid  <= 1'b0;
      r_target <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_delta  <= w_delta_nxt;
      r_valid  <= w_valid_nxt;
      r_target <= w_target_nxt;
      r_shift  <= w_shift_nxt;
    end
  end
endmodule
